axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
//  AXI4 responder terminating an axi_channel at an on-chip single-port RAM of MEM_WORDS x DATA_WIDTH.
//  Sits at the slave end of an AXI path, e.g. behind a buffer or crossbar port; serves as scratchpad/boot RAM.
//  One outstanding write burst and one outstanding read burst; both share the RAM via alternating arbitration.
// PARAMETERS
//  MEM_WORDS  1024  RAM depth in DATA_WIDTH words; power of two; byte span = MEM_WORDS*DATA_WIDTH/8
//  (ID/ADDR/DATA/USER widths are taken from the connected axi_channel; user fields are driven 0)
// PORTS
//  clk     in   1    clock; the interface clk/rstn members are not used
//  rst     in   1    asynchronous, active-high reset
//  master  axi_channel.slave  -  full AXI4 bundle: AW, W, B, AR, R channels
// BEHAVIOUR
//  Reset (async, immediate): aw_ready=w_ready=ar_ready=0, b_valid=r_valid=0; b_id/b_resp/r_id/r_data/r_resp/r_last=0;
//   FSMs to idle; arbitration priority to write. RAM contents are not cleared. Reset mid-burst abandons it.
//  Handshake: VALID/READY AXI rules; once b_valid/r_valid is high, it and all payload stay stable until ready.
//  Write FSM: W_IDLE (aw_ready=1) -AW hs-> W_DATA -last counted beat-> W_RESP (b_valid=1) -b_ready-> W_IDLE.
//   AW hs latches id, addr, len, size, burst; beat counter cleared. aw_ready=0 outside W_IDLE.
//   W_DATA: w_ready=1 only when RAM granted to write; each W hs writes bytes where w_strb=1 to word addr>>log2(DATA_WIDTH/8).
//   Burst ends on beat len+1 regardless of w_last; w_last mismatch (early or missing) -> b_resp=SLVERR.
//  Read FSM: R_IDLE (ar_ready=1) -AR hs-> R_ADDR -granted RAM read-> R_DATA (r_valid=1 next cycle, RAM latency 1)
//   -r_ready-> R_ADDR, or R_IDLE after beat len+1. r_last=1 on beat len+1 only. Throughput 1 beat per 2 cycles.
//  Arbitration: RAM wanted by W_DATA with w_valid, and by R_ADDR. One requester -> granted. Both -> grant the one
//   not granted last contested cycle (toggle bit); guarantees alternation, no starvation.
//  Address generation per beat, step = 2^size bytes:
//   FIXED: address unchanged. INCR: addr += step (no 4 KiB check; caller obeys AXI).
//   WRAP: boundary = (len+1)*step; addr = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)).
//   Reserved burst type 2'b11 treated as INCR. Narrow sizes honoured via strobes/lane positions; r_data full word.
//  Range: any beat address >= byte span -> that write beat dropped and b_resp=SLVERR;
//   that read beat returns r_data=0, r_resp=SLVERR. Otherwise resp=OKAY (2'b00). EXOKAY never returned.
//  IDs: b_id = latched aw_id, r_id = latched ar_id. Lock/cache/prot/qos/region ignored.
//  Simultaneous AW and AR hs in one cycle: both accepted independently.
//  Read of a word written in the same burst pairing: ordering is grant order; no forwarding.
// TESTING (DATA_WIDTH=32, MEM_WORDS=256 -> 1 KiB)
//  1 AW id=3 addr=0x10 len=0, W 0xDEADBEEF strb=0xF; AR id=5 addr=0x10 -> b_id=3 b_resp=0; r_data=0xDEADBEEF r_id=5 r_last=1.
//  2 INCR len=3 size=2 at 0x100, data 1..4, 2nd beat strb=0x3 over prior 0xFFFFFFFF -> readback 1,0xFFFF0002,3,4.
//  3 WRAP len=3 size=2 addr=0x08 -> beats written at 0x08,0x0C,0x00,0x04; INCR read from 0x00 returns them in order.
//  4 Write len=1 at 0x3FC -> beat 2 (0x400) dropped, b_resp=2'b10; read len=1 at 0x3FC -> resp OKAY then SLVERR, data 0, r_last on 2nd.
//  5 Concurrent 4-beat write and 4-beat read, r_ready low 5 cycles mid-burst -> grants alternate, r_* stable while stalled, both complete.
//  6 rst pulsed during beat 2 of a write -> ready/valid 0 at once; after release aw_ready=1, earlier-written words intact.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// AXI4 channel bundle (AW, W, B, AR, R) shared between a manager and a subordinate.
interface axi_channel #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 1
);
  logic                      clk;
  logic                      rstn;

  logic [ID_WIDTH-1:0]       aw_id;
  logic [ADDR_WIDTH-1:0]     aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [USER_WIDTH-1:0]     aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [DATA_WIDTH-1:0]     w_data;
  logic [DATA_WIDTH/8-1:0]   w_strb;
  logic                      w_last;
  logic [USER_WIDTH-1:0]     w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [ID_WIDTH-1:0]       b_id;
  logic [1:0]                b_resp;
  logic [USER_WIDTH-1:0]     b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [ID_WIDTH-1:0]       ar_id;
  logic [ADDR_WIDTH-1:0]     ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [USER_WIDTH-1:0]     ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [ID_WIDTH-1:0]       r_id;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [USER_WIDTH-1:0]     r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport slave (
    input  clk, rstn,
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

  modport master (
    input  clk, rstn,
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 subordinate backed by a single-port RAM; one write and one read burst in flight,
// sharing the RAM port through an alternating arbiter.
module axi_sram_slave #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic      clk,
  input  logic      rst,
  axi_channel.slave master
);
  localparam int unsigned DW   = $bits(master.w_data);
  localparam int unsigned AW   = $bits(master.aw_addr);
  localparam int unsigned IW   = $bits(master.aw_id);
  localparam int unsigned SB   = DW / 8;
  localparam int unsigned OFFS = $clog2(SB);
  localparam int unsigned IDXW = $clog2(MEM_WORDS);
  localparam logic [AW:0] SPAN = (AW + 1)'(MEM_WORDS * SB);
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {StWIdle, StWData, StWResp} w_state_e;
  typedef enum logic [1:0] {StRIdle, StRAddr, StRData} r_state_e;

  w_state_e      w_state_q, w_state_d;
  r_state_e      r_state_q, r_state_d;
  logic [IW-1:0] w_id_q, r_id_q;
  logic [AW-1:0] w_addr_q, r_addr_q;
  logic [7:0]    w_len_q, r_len_q, w_cnt_q, r_cnt_q;
  logic [2:0]    w_size_q, r_size_q;
  logic [1:0]    w_burst_q, r_burst_q;
  logic          w_err_q, prio_w_q;
  logic [1:0]    b_resp_q, r_resp_q;
  logic [DW-1:0] r_data_q;
  logic          r_last_q;
  logic [DW-1:0] mem [MEM_WORDS];

  logic aw_hs, ar_hs, r_hs, w_req, r_req, w_gnt, r_gnt;
  logic w_beat_last, w_beat_ok, w_beat_err, r_beat_ok;

  function automatic logic [AW-1:0] next_addr(logic [AW-1:0] addr, logic [2:0] size,
                                               logic [7:0] len, logic [1:0] burst);
    logic [AW-1:0] step, bnd;
    step = AW'(1) << size;
    bnd  = (AW'(len) + AW'(1)) * step;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~(bnd - AW'(1))) | ((addr + step) & (bnd - AW'(1)));
      default: next_addr = addr + step;
    endcase
  endfunction

  function automatic logic in_span(logic [AW-1:0] addr);
    return {1'b0, addr} < SPAN;
  endfunction

  // Contested cycles go to whoever lost the previous contest.
  assign w_req = (w_state_q == StWData) && master.w_valid;
  assign r_req = (r_state_q == StRAddr);
  assign w_gnt = w_req && (!r_req || prio_w_q);
  assign r_gnt = r_req && !w_gnt;

  assign master.aw_ready = (w_state_q == StWIdle) && !rst;
  assign master.ar_ready = (r_state_q == StRIdle) && !rst;
  assign master.w_ready  = w_gnt;
  assign master.b_valid  = (w_state_q == StWResp);
  assign master.b_id     = w_id_q;
  assign master.b_resp   = b_resp_q;
  assign master.b_user   = '0;
  assign master.r_valid  = (r_state_q == StRData);
  assign master.r_id     = r_id_q;
  assign master.r_data   = r_data_q;
  assign master.r_resp   = r_resp_q;
  assign master.r_last   = r_last_q;
  assign master.r_user   = '0;

  assign aw_hs       = master.aw_valid && master.aw_ready;
  assign ar_hs       = master.ar_valid && master.ar_ready;
  assign r_hs        = master.r_valid && master.r_ready;
  assign w_beat_last = (w_cnt_q == w_len_q);
  assign w_beat_ok   = in_span(w_addr_q);
  assign w_beat_err  = !w_beat_ok || (master.w_last != w_beat_last);
  assign r_beat_ok   = in_span(r_addr_q);

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      StWIdle: if (aw_hs) w_state_d = StWData;
      StWData: if (w_gnt && w_beat_last) w_state_d = StWResp;
      StWResp: if (master.b_ready) w_state_d = StWIdle;
      default: w_state_d = StWIdle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      StRIdle: if (ar_hs) r_state_d = StRAddr;
      StRAddr: if (r_gnt) r_state_d = StRData;
      StRData: if (r_hs) r_state_d = r_last_q ? StRIdle : StRAddr;
      default: r_state_d = StRIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= StWIdle;
      r_state_q <= StRIdle;
      w_id_q    <= '0;
      r_id_q    <= '0;
      w_addr_q  <= '0;
      r_addr_q  <= '0;
      w_len_q   <= '0;
      r_len_q   <= '0;
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
      w_size_q  <= '0;
      r_size_q  <= '0;
      w_burst_q <= '0;
      r_burst_q <= '0;
      w_err_q   <= 1'b0;
      prio_w_q  <= 1'b1;
      b_resp_q  <= '0;
      r_resp_q  <= '0;
      r_data_q  <= '0;
      r_last_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      if (w_req && r_req) prio_w_q <= !w_gnt;
      if (aw_hs) begin
        w_id_q    <= master.aw_id;
        w_addr_q  <= master.aw_addr;
        w_len_q   <= master.aw_len;
        w_size_q  <= master.aw_size;
        w_burst_q <= master.aw_burst;
        w_cnt_q   <= '0;
        w_err_q   <= 1'b0;
      end
      if (w_gnt) begin
        w_cnt_q  <= w_cnt_q + 8'd1;
        w_addr_q <= next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
        w_err_q  <= w_err_q || w_beat_err;
        if (w_beat_last) b_resp_q <= (w_err_q || w_beat_err) ? SLVERR : 2'b00;
      end
      if (ar_hs) begin
        r_id_q    <= master.ar_id;
        r_addr_q  <= master.ar_addr;
        r_len_q   <= master.ar_len;
        r_size_q  <= master.ar_size;
        r_burst_q <= master.ar_burst;
        r_cnt_q   <= '0;
      end
      if (r_gnt) begin
        r_data_q <= r_beat_ok ? mem[r_addr_q[OFFS +: IDXW]] : '0;
        r_resp_q <= r_beat_ok ? 2'b00 : SLVERR;
        r_last_q <= (r_cnt_q == r_len_q);
      end
      if (r_hs) begin
        r_cnt_q  <= r_cnt_q + 8'd1;
        r_addr_q <= next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_gnt && w_beat_ok) begin
      for (int b = 0; b < int'(SB); b++) begin
        if (master.w_strb[b]) mem[w_addr_q[OFFS +: IDXW]][8*b +: 8] <= master.w_data[8*b +: 8];
      end
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{master.clk, master.rstn, master.aw_lock, master.aw_cache, master.aw_prot,
                         master.aw_qos, master.aw_region, master.aw_user, master.w_user,
                         master.ar_lock, master.ar_cache, master.ar_prot, master.ar_qos,
                         master.ar_region, master.ar_user};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised bench for axi_sram_slave: byte-array reference model feeding B/R scoreboards.
module tb_axi_sram_slave;
  localparam int unsigned SPAN = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_channel #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(1)) bus ();
  axi_sram_slave #(.MEM_WORDS(256)) dut (.clk(clk), .rst(rst), .master(bus));

  assign bus.clk  = clk;
  assign bus.rstn = ~rst;

  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [7:0]  model [SPAN];
  logic [31:0] wdata [256];
  logic [3:0]  wstrb [256];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event required one within bound", name);
  endtask

  function automatic int unsigned beat_addr(input int unsigned start, input int size,
                                            input int len, input int burst, input int i);
    int unsigned step, bnd, base;
    step = 1 << size;
    if (burst == 0) return start;
    if (burst == 2) begin
      bnd  = (len + 1) * step;
      base = start - (start % bnd);
      return base + ((start - base + i * step) % bnd);
    end
    return start + i * step;
  endfunction

  function automatic bit probe(input int which);
    case (which)
      0: return bus.aw_ready;
      1: return bus.w_ready;
      2: return bus.ar_ready;
      3: return bus.b_valid;
      default: return bus.r_valid;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name);
    int n = 0;
    @(negedge clk);
    while (!probe(which) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!probe(which)) bad(name);
  endtask

  // Scoreboard monitor: pops expectations on handshakes, checks hold while stalled.
  logic        b_stall, r_stall;
  logic [5:0]  b_snap;
  logic [38:0] r_snap;
  b_exp_t      be;
  r_exp_t      re;
  always @(negedge clk) begin
    if (rst) begin
      b_stall = 1'b0;
      r_stall = 1'b0;
    end else begin
      if (b_stall) check("b_hold", {bus.b_valid, bus.b_id, bus.b_resp}, {1'b1, b_snap});
      if (r_stall) check("r_hold", {bus.r_valid, bus.r_id, bus.r_data, bus.r_resp, bus.r_last},
                         {1'b1, r_snap});
      if (bus.b_valid && bus.b_ready) begin
        if (bq.size() == 0) bad("b_unexpected");
        else begin
          be = bq.pop_front();
          check("b_id", bus.b_id, be.id);
          check("b_resp", bus.b_resp, be.resp);
          check("b_user", bus.b_user, 0);
        end
      end
      if (bus.r_valid && bus.r_ready) begin
        if (rq.size() == 0) bad("r_unexpected");
        else begin
          re = rq.pop_front();
          check("r_id", bus.r_id, re.id);
          check("r_data", bus.r_data, re.data);
          check("r_resp", bus.r_resp, re.resp);
          check("r_last", bus.r_last, re.last);
          check("r_user", bus.r_user, 0);
        end
      end
      b_stall = bus.b_valid && !bus.b_ready;
      b_snap  = {bus.b_id, bus.b_resp};
      r_stall = bus.r_valid && !bus.r_ready;
      r_snap  = {bus.r_id, bus.r_data, bus.r_resp, bus.r_last};
    end
  end

  task automatic aw_send(input logic [3:0] id, input int unsigned addr, input int len,
                         input int size, input int burst);
    bus.aw_id    = id;
    bus.aw_addr  = addr;
    bus.aw_len   = 8'(len);
    bus.aw_size  = 3'(size);
    bus.aw_burst = 2'(burst);
    bus.aw_valid = 1'b1;
    wait_for(0, "aw_timeout");
    @(posedge clk); #1;
    bus.aw_valid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    if ($urandom_range(3) == 0) begin
      @(posedge clk); #1;
    end
    bus.w_data  = d;
    bus.w_strb  = s;
    bus.w_last  = l;
    bus.w_valid = 1'b1;
    wait_for(1, "w_timeout");
    @(posedge clk); #1;
    bus.w_valid = 1'b0;
  endtask

  // last_mode: 0 correct w_last, 1 w_last on first beat, 2 w_last never asserted.
  task automatic do_write(input logic [3:0] id, input int unsigned addr, input int len,
                          input int size, input int burst, input int last_mode);
    logic [1:0]  resp = 2'b00;
    int unsigned a;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, size, len, burst, i);
      if (a >= SPAN) resp = 2'b10;
      else for (int b = 0; b < 4; b++) if (wstrb[i][b]) model[(a & ~32'd3) + b] = wdata[i][8*b +: 8];
    end
    if ((last_mode == 1 && len > 0) || last_mode == 2) resp = 2'b10;
    bq.push_back('{id: id, resp: resp});
    aw_send(id, addr, len, size, burst);
    for (int i = 0; i <= len; i++)
      w_beat(wdata[i], wstrb[i], last_mode == 0 ? (i == len) : (last_mode == 1 && i == 0));
    wait_for(3, "b_timeout");
    @(posedge clk);
    repeat ($urandom_range(2)) @(posedge clk);
    #1 bus.b_ready = 1'b1;
    @(posedge clk); #1;
    bus.b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input int unsigned addr, input int len,
                         input int size, input int burst, input int stall_beat, input int stall);
    int unsigned a, w;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, size, len, burst, i);
      w = a & ~32'd3;
      if (a >= SPAN) rq.push_back('{id: id, data: 32'h0, resp: 2'b10, last: (i == len)});
      else rq.push_back('{id: id, data: {model[w+3], model[w+2], model[w+1], model[w]},
                          resp: 2'b00, last: (i == len)});
    end
    bus.ar_id    = id;
    bus.ar_addr  = addr;
    bus.ar_len   = 8'(len);
    bus.ar_size  = 3'(size);
    bus.ar_burst = 2'(burst);
    bus.ar_valid = 1'b1;
    wait_for(2, "ar_timeout");
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wait_for(4, "r_timeout");
      @(posedge clk);
      if (i == stall_beat) repeat (stall) @(posedge clk);
      #1 bus.r_ready = 1'b1;
      @(posedge clk); #1;
      bus.r_ready = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1);
  end

  initial begin
    int unsigned addr;
    int          len, size, burst;
    logic [3:0]  id;
    rst = 1'b1;
    {bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready} = '0;
    {bus.aw_id, bus.aw_addr, bus.aw_len, bus.aw_size, bus.aw_burst} = '0;
    {bus.aw_lock, bus.aw_cache, bus.aw_prot, bus.aw_qos, bus.aw_region, bus.aw_user} = '0;
    {bus.ar_id, bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_burst} = '0;
    {bus.ar_lock, bus.ar_cache, bus.ar_prot, bus.ar_qos, bus.ar_region, bus.ar_user} = '0;
    {bus.w_data, bus.w_strb, bus.w_last, bus.w_user} = '0;
    #2;
    check("rst_readies", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 0);
    check("rst_valids", {bus.b_valid, bus.r_valid}, 0);
    check("rst_payload", {bus.b_id, bus.b_resp, bus.r_id, bus.r_data, bus.r_resp, bus.r_last}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_aw_ready", bus.aw_ready, 1);
    check("idle_ar_ready", bus.ar_ready, 1);

    // Give every RAM byte a known value.
    for (int i = 0; i < 256; i++) begin
      wdata[i] = $urandom;
      wstrb[i] = 4'hF;
    end
    do_write(4'd0, 0, 255, 2, 1, 0);

    wdata[0] = 32'hDEADBEEF;
    do_write(4'd3, 32'h10, 0, 2, 1, 0);
    do_read(4'd5, 32'h10, 0, 2, 1, -1, 0);

    wdata[0] = 32'hFFFF_FFFF;
    do_write(4'd1, 32'h104, 0, 2, 1, 0);
    for (int i = 0; i < 4; i++) begin
      wdata[i] = 32'(i + 1);
      wstrb[i] = (i == 1) ? 4'h3 : 4'hF;
    end
    do_write(4'd2, 32'h100, 3, 2, 1, 0);
    do_read(4'd4, 32'h100, 3, 2, 1, 1, 2);

    for (int i = 0; i < 4; i++) begin
      wdata[i] = 32'hA0A0_0000 + 32'(i);
      wstrb[i] = 4'hF;
    end
    do_write(4'd6, 32'h08, 3, 2, 2, 0);
    do_read(4'd7, 32'h00, 3, 2, 1, -1, 0);

    do_write(4'd8, 32'h3FC, 1, 2, 1, 0);
    do_read(4'd9, 32'h3FC, 1, 2, 1, -1, 0);
    do_write(4'd10, 32'h20, 1, 2, 1, 1);
    do_write(4'd11, 32'h28, 1, 2, 1, 2);
    do_read(4'd12, 32'h20, 3, 2, 1, -1, 0);

    for (int t = 0; t < 24; t++) begin
      burst = $urandom_range(3);
      size  = $urandom_range(2);
      len   = (burst == 2) ? (2 << $urandom_range(2)) - 1 : $urandom_range(7);
      addr  = $urandom_range(32'h47F) & ~((32'd1 << size) - 1);
      id    = 4'($urandom);
      for (int i = 0; i <= len; i++) begin
        wdata[i] = $urandom;
        wstrb[i] = 4'($urandom) & (4'((1 << (1 << size)) - 1)
                   << (beat_addr(addr, size, len, burst, i) % 4));
      end
      do_write(id, addr, len, size, burst, 0);
      do_read(~id, addr, len, size, burst, $urandom_range(len), $urandom_range(3));
    end

    for (int i = 0; i < 4; i++) begin
      wdata[i] = $urandom;
      wstrb[i] = 4'hF;
    end
    fork
      do_write(4'd13, 32'h200, 3, 2, 1, 0);
      do_read(4'd14, 32'h300, 3, 2, 1, 2, 5);
    join

    // Reset in the middle of the second write beat.
    wdata[0] = 32'h1234_5678;
    aw_send(4'd15, 32'h40, 3, 2, 1);
    w_beat(wdata[0], 4'hF, 1'b0);
    for (int b = 0; b < 4; b++) model[32'h40 + b] = wdata[0][8*b +: 8];
    bus.w_data  = 32'h0BAD_0BAD;
    bus.w_strb  = 4'hF;
    bus.w_valid = 1'b1;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_readies", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 0);
    check("mid_rst_valids", {bus.b_valid, bus.r_valid}, 0);
    bus.w_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_aw_ready", bus.aw_ready, 1);
    do_read(4'd2, 32'h40, 3, 2, 1, -1, 0);

    check("b_queue_drained", bq.size(), 0);
    check("r_queue_drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
